// File: rtl/key_pulse_gen_pkg.sv
// -----------------------------------------------------------------------------
// key_pulse_gen_pkg
// Shared definitions for the watch push-button front end:
//   - key_state_e : 3-bit FSM state encodings for the key pulse generator
//   - KEY_*_1K    : default timing constants for a 1 kHz system clock
//   - key_max3    : elaboration-time helper for counter limits
// -----------------------------------------------------------------------------
package key_pulse_gen_pkg;

  typedef enum logic [2:0] {
    KEY_IDLE       = 3'd0,
    KEY_DB_PRESS   = 3'd1,
    KEY_HELD       = 3'd2,
    KEY_REPEAT     = 3'd3,
    KEY_DB_RELEASE = 3'd4
  } key_state_e;

  // Defaults for a 1 kHz clock: 20 ms debounce, 0.5 s repeat delay,
  // 150 ms repeat period.
  localparam int unsigned KEY_DEBOUNCE_CNT_1K  = 20;
  localparam int unsigned KEY_REPEAT_DELAY_1K  = 500;
  localparam int unsigned KEY_REPEAT_PERIOD_1K = 150;
  localparam int unsigned KEY_CNT_WIDTH_1K     = 10;

  function automatic int unsigned key_max3(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_pulse_gen_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous level. Both flops reset
// asynchronously to 0. Reusable for every button of the watch.
// Ports:
//   clock  in  system clock, rising edge
//   reset  in  asynchronous active-high reset
//   d_i    in  asynchronous input level
//   q_o    out level synchronized to clock (2-cycle latency)
// -----------------------------------------------------------------------------
module sync_2ff (
  input  logic clock,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/key_pulse_gen.sv
// -----------------------------------------------------------------------------
// key_pulse_gen
// Debounces one raw push-button and emits a one-cycle pulse per accepted
// press, plus optional auto-repeat pulses while the key is held.
// Optional feature macro: KEY_AUTO_REPEAT_EN (adds the REPEAT state).
// Parameters:
//   DEBOUNCE_CNT  cycles of stable key needed to accept press/release (>=2)
//   REPEAT_DELAY  cycles in HELD before the first repeat pulse (>=2)
//   REPEAT_PERIOD cycles between repeat pulses (>=2)
//   CNT_WIDTH     width of the shared cycle counter
// Ports:
//   clock    in  system clock, rising edge
//   reset    in  asynchronous active-high reset, clears all state
//   key      in  raw, bouncing, asynchronous button level (active-high)
//   pulse    out registered single-cycle pulse per press / repeat
//   pressed  out registered debounced key level
// -----------------------------------------------------------------------------
module key_pulse_gen
  import key_pulse_gen_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CNT  = KEY_DEBOUNCE_CNT_1K,
  parameter int unsigned REPEAT_DELAY  = KEY_REPEAT_DELAY_1K,
  parameter int unsigned REPEAT_PERIOD = KEY_REPEAT_PERIOD_1K,
  parameter int unsigned CNT_WIDTH     = KEY_CNT_WIDTH_1K
) (
  input  logic clock,
  input  logic reset,
  input  logic key,
  output logic pulse,
  output logic pressed
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] DB_LIM  = CNT_WIDTH'(DEBOUNCE_CNT);
`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [CNT_WIDTH-1:0] RD_LIM  = CNT_WIDTH'(REPEAT_DELAY);
  localparam logic [CNT_WIDTH-1:0] RP_LIM  = CNT_WIDTH'(REPEAT_PERIOD);
`else
  // Without repeat the HELD count is never compared; it only has to stop
  // somewhere inside the counter range instead of wrapping.
  localparam logic [CNT_WIDTH-1:0] CNT_TOP =
    CNT_WIDTH'(key_max3(DEBOUNCE_CNT, REPEAT_DELAY, REPEAT_PERIOD));
`endif

  logic                 key_s;
  key_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 pulse_q, pulse_d;
  logic                 pressed_q, pressed_d;

  sync_2ff u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   (key),
    .q_o   (key_s)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= KEY_IDLE;
      cnt_q     <= '0;
      pulse_q   <= 1'b0;
      pressed_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      pressed_q <= pressed_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pulse_d   = 1'b0;
    pressed_d = pressed_q;
    case (state_q)
      KEY_IDLE: begin
        if (key_s) begin
          state_d = KEY_DB_PRESS;
          cnt_d   = CNT_ONE;
        end
      end
      KEY_DB_PRESS: begin
        if (!key_s) begin
          state_d = KEY_IDLE;          // glitch: drop it silently
        end else if (cnt_q == DB_LIM) begin
          state_d   = KEY_HELD;
          pulse_d   = 1'b1;
          pressed_d = 1'b1;
          cnt_d     = CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      KEY_HELD: begin
        if (!key_s) begin
          state_d = KEY_DB_RELEASE;
          cnt_d   = CNT_ONE;
`ifdef KEY_AUTO_REPEAT_EN
        end else if (cnt_q == RD_LIM) begin
          state_d = KEY_REPEAT;
          pulse_d = 1'b1;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
`else
        end else if (cnt_q != CNT_TOP) begin
          cnt_d = cnt_q + CNT_ONE;
        end
`endif
      end
`ifdef KEY_AUTO_REPEAT_EN
      KEY_REPEAT: begin
        if (!key_s) begin
          state_d = KEY_DB_RELEASE;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == RP_LIM) begin
          pulse_d = 1'b1;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
`endif
      KEY_DB_RELEASE: begin
        // A release bounce returns to HELD and restarts the repeat delay.
        if (key_s) begin
          state_d = KEY_HELD;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == DB_LIM) begin
          state_d   = KEY_IDLE;
          pressed_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        // Illegal encodings (and REPEAT when it is not built) recover to IDLE.
        state_d   = KEY_IDLE;
        cnt_d     = '0;
        pressed_d = 1'b0;
      end
    endcase
  end

  assign pulse   = pulse_q;
  assign pressed = pressed_q;

endmodule

// File: tb/tb_key_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_key_pulse_gen
// Directed bench for key_pulse_gen with DEBOUNCE_CNT=4, REPEAT_DELAY=10,
// REPEAT_PERIOD=3. Step k drives key before edge E(k), and outputs are
// checked 1 time unit after that edge. Expectations follow the build's
// KEY_AUTO_REPEAT_EN setting.
// -----------------------------------------------------------------------------
module tb_key_pulse_gen;

  logic clock;
  logic reset;
  logic key;
  logic pulse;
  logic pressed;

  int total = 0;
  int bad   = 0;

  key_pulse_gen #(
    .DEBOUNCE_CNT  (4),
    .REPEAT_DELAY  (10),
    .REPEAT_PERIOD (3),
    .CNT_WIDTH     (10)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .key     (key),
    .pulse   (pulse),
    .pressed (pressed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    key   = 1'b0;
    tick();
    tick();
    check_val("reset pulse", int'(pulse), 0);
    check_val("reset pressed", int'(pressed), 0);
    reset = 1'b0;
  endtask

  // Hold for 30 cycles: press pulse at E6, repeats at E16 then every 3
  // cycles; E31 still sees the synchronized key high.
  function automatic int exp_hold30(input int k);
`ifdef KEY_AUTO_REPEAT_EN
    return int'(k == 6 || (k >= 16 && k <= 31 && (k - 16) % 3 == 0));
`else
    return int'(k == 6);
`endif
  endfunction

  // Release bounce: DB_RELEASE at E10/E11, back to HELD at E12, so the
  // first repeat lands at E22, then E25, E28 before release takes over.
  function automatic int exp_bounce_rel(input int k);
`ifdef KEY_AUTO_REPEAT_EN
    return int'(k == 6 || k == 22 || k == 25 || k == 28);
`else
    return int'(k == 6);
`endif
  endfunction

  initial begin
    logic pat [5];
    int   npul;
    int   exp_cnt;

    reset = 1'b1;
    key   = 1'b0;

    // ---- clean press held 8 cycles ----
    do_reset();
    npul = 0;
    for (int k = 0; k < 18; k++) begin
      key = (k < 8) ? 1'b1 : 1'b0;
      tick();
      check_val($sformatf("clean pulse E%0d", k), int'(pulse), int'(k == 6));
      check_val($sformatf("clean pressed E%0d", k), int'(pressed), int'(k >= 6 && k < 14));
      npul += int'(pulse);
    end
    check_val("clean pulse count", npul, 1);
    $display("clean press: pulses=%0d", npul);

    // ---- bouncing press 1,0,1,1,0 then steady 1 ----
    do_reset();
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    npul = 0;
    for (int k = 0; k < 15; k++) begin
      key = (k < 5) ? pat[k] : 1'b1;
      tick();
      check_val($sformatf("bounce pulse E%0d", k), int'(pulse), int'(k == 11));
      check_val($sformatf("bounce pressed E%0d", k), int'(pressed), int'(k >= 11));
      npul += int'(pulse);
    end
    key = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    check_val("bounce released", int'(pressed), 0);
    check_val("bounce pulse count", npul, 1);
    $display("bouncing press: pulses=%0d", npul);

    // ---- hold 30 cycles ----
    do_reset();
    npul = 0;
    for (int k = 0; k < 42; k++) begin
      key = (k < 30) ? 1'b1 : 1'b0;
      tick();
      check_val($sformatf("hold pulse E%0d", k), int'(pulse), exp_hold30(k));
      check_val($sformatf("hold pressed E%0d", k), int'(pressed), int'(k >= 6 && k < 36));
      npul += int'(pulse);
    end
`ifdef KEY_AUTO_REPEAT_EN
    exp_cnt = 7;
`else
    exp_cnt = 1;
`endif
    check_val("hold pulse count", npul, exp_cnt);
    $display("hold 30: pulses=%0d", npul);

    // ---- release bounce while HELD ----
    do_reset();
    npul = 0;
    for (int k = 0; k < 40; k++) begin
      key = (k < 8) ? 1'b1 : (k < 10) ? 1'b0 : (k < 28) ? 1'b1 : 1'b0;
      tick();
      check_val($sformatf("relbounce pulse E%0d", k), int'(pulse), exp_bounce_rel(k));
      check_val($sformatf("relbounce pressed E%0d", k), int'(pressed), int'(k >= 6 && k < 34));
      npul += int'(pulse);
    end
    $display("release bounce: pulses=%0d", npul);

    // ---- reset in REPEAT mid-operation ----
    do_reset();
    for (int k = 0; k < 20; k++) begin
      key = 1'b1;
      tick();
      check_val($sformatf("rstrep pulse E%0d", k), int'(pulse), exp_hold30(k));
    end
    check_val("rstrep pressed before", int'(pressed), 1);
    #2 reset = 1'b1;
    #1;
    check_val("rstrep async pulse", int'(pulse), 0);
    check_val("rstrep async pressed", int'(pressed), 0);
    tick();
    check_val("rstrep held pressed", int'(pressed), 0);
    reset = 1'b0;
    for (int k = 0; k < 9; k++) begin
      tick();
      check_val($sformatf("rstrep re pulse F%0d", k), int'(pulse), int'(k == 6));
      check_val($sformatf("rstrep re pressed F%0d", k), int'(pressed), int'(k >= 6));
    end
    $display("reset in repeat: pressed=%0d", pressed);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
